// File: rtl/pc_gen.sv
// Fetch-stage program counter: steps, holds on stall, redirects on a branch strobe (buffered across stalls).
// Latency: pc_o is registered, so a redirect or step shows on pc_o one edge after it is selected; pc_next_o is that value now.
// Backpressure: stall_i freezes pc_o and masks fetch_valid_o; a strobe seen during a stall waits in the pending register.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter int              PC_STEP      = 1,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0010,
    parameter int              ALIGN_BITS   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_addr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            fetch_valid_o,
    output logic            pending_o,
    output logic            misalign_o
);

    // Mask is zero when ALIGN_BITS is 0, which disables the alignment check.
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_tgt_q;
    logic            pend_q;
    logic            misalign_q;
    logic            started_q;

    logic            req;
    logic [XLEN-1:0] tgt;
    logic            tgt_misaligned;

    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] pend_tgt_nxt;
    logic            pend_nxt;
    logic            misalign_nxt;

    assign req            = branch_taken_i | pend_q;
    assign tgt            = branch_taken_i ? branch_addr_i : pend_tgt_q;
    assign tgt_misaligned = |(tgt & ALIGN_MASK);

    always_comb begin
        pc_nxt       = pc_q + XLEN'(PC_STEP);
        pend_tgt_nxt = pend_tgt_q;
        pend_nxt     = pend_q;
        misalign_nxt = 1'b0;
        if (stall_i) begin
            pc_nxt = pc_q;
            // A newer strobe always replaces whatever was buffered.
            if (branch_taken_i) begin
                pend_tgt_nxt = branch_addr_i;
                pend_nxt     = 1'b1;
            end
        end else if (req) begin
            pc_nxt       = tgt_misaligned ? TRAP_VECTOR : tgt;
            pend_nxt     = 1'b0;
            misalign_nxt = tgt_misaligned;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            pend_tgt_q <= '0;
            pend_q     <= 1'b0;
            misalign_q <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            pc_q       <= pc_nxt;
            pend_tgt_q <= pend_tgt_nxt;
            pend_q     <= pend_nxt;
            misalign_q <= misalign_nxt;
            started_q  <= 1'b1;
        end
    end

    assign pc_o          = pc_q;
    assign pc_next_o     = rst ? RESET_VECTOR : pc_nxt;
    assign fetch_valid_o = started_q & ~stall_i;
    assign pending_o     = pend_q;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance with the alignment check off, one with ALIGN_BITS=2, sharing stimulus.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_addr_i = '0;

    logic [31:0] pc_a, pc_next_a, pc_b, pc_next_b;
    logic        fv_a, pend_a, mis_a, fv_b, pend_b, mis_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen #(.ALIGN_BITS(0)) dut_a (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_taken_i(branch_taken_i),
        .branch_addr_i(branch_addr_i), .pc_o(pc_a), .pc_next_o(pc_next_a),
        .fetch_valid_o(fv_a), .pending_o(pend_a), .misalign_o(mis_a)
    );

    pc_gen #(.ALIGN_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_taken_i(branch_taken_i),
        .branch_addr_i(branch_addr_i), .pc_o(pc_b), .pc_next_o(pc_next_b),
        .fetch_valid_o(fv_b), .pending_o(pend_b), .misalign_o(mis_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held across a couple of edges.
        #1 rst = 1'b1;
        #1;
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_pend", {31'b0, pend_a}, 32'h0);
        chk("rst_mis", {31'b0, mis_a}, 32'h0);
        chk("rst_fv", {31'b0, fv_a}, 32'h0);
        chk("rst_pcnext", pc_next_a, 32'h0);
        step();
        step();
        rst = 1'b0;
        #1;

        // Test 1: free-run after reset.
        chk("t1_pc0", pc_a, 32'h0);
        chk("t1_fv0", {31'b0, fv_a}, 32'h0);
        chk("t1_pcnext0", pc_next_a, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t1_pc", pc_a, 32'(i));
            chk("t1_fv", {31'b0, fv_a}, 32'h1);
        end

        // Test 2: redirect without stall, including a target of zero.
        step();
        chk("t2_pc5", pc_a, 32'h5);
        branch_taken_i = 1'b1;
        branch_addr_i  = 32'h40;
        #1 chk("t2_pcnext", pc_next_a, 32'h40);
        step();
        branch_taken_i = 1'b0;
        chk("t2_pc40", pc_a, 32'h40);
        chk("t2_mis", {31'b0, mis_a}, 32'h0);
        step();
        chk("t2_pc41", pc_a, 32'h41);
        branch_taken_i = 1'b1;
        branch_addr_i  = 32'h0;
        step();
        branch_taken_i = 1'b0;
        chk("t2_pc_zero", pc_a, 32'h0);
        for (int i = 0; i < 8; i++) step();
        chk("t3_pc8", pc_a, 32'h8);

        // Test 3: three stall cycles, strobe in the second one.
        stall_i = 1'b1;
        #1 chk("t3_fv_stall", {31'b0, fv_a}, 32'h0);
        step();
        chk("t3_hold1", pc_a, 32'h8);
        branch_taken_i = 1'b1;
        branch_addr_i  = 32'h80;
        step();
        branch_taken_i = 1'b0;
        chk("t3_hold2", pc_a, 32'h8);
        chk("t3_pend", {31'b0, pend_a}, 32'h1);
        #1 chk("t3_pcnext_hold", pc_next_a, 32'h8);
        step();
        stall_i = 1'b0;
        chk("t3_hold3", pc_a, 32'h8);
        chk("t3_pend3", {31'b0, pend_a}, 32'h1);
        #1 chk("t3_pcnext_tgt", pc_next_a, 32'h80);
        step();
        chk("t3_pc80", pc_a, 32'h80);
        chk("t3_pend_clr", {31'b0, pend_a}, 32'h0);
        chk("t3_fv", {31'b0, fv_a}, 32'h1);

        // Test 4: two strobes in one stall, the later one wins.
        stall_i = 1'b1;
        branch_taken_i = 1'b1;
        branch_addr_i  = 32'h80;
        step();
        branch_addr_i  = 32'h90;
        step();
        branch_taken_i = 1'b0;
        stall_i = 1'b0;
        chk("t4_hold", pc_a, 32'h80);
        chk("t4_pend", {31'b0, pend_a}, 32'h1);
        step();
        chk("t4_pc90", pc_a, 32'h90);
        chk("t4_pend_clr", {31'b0, pend_a}, 32'h0);

        // Test 5: misaligned redirect traps on the ALIGN_BITS=2 instance only.
        branch_taken_i = 1'b1;
        branch_addr_i  = 32'h102;
        step();
        branch_taken_i = 1'b0;
        chk("t5_trap_pc", pc_b, 32'h10);
        chk("t5_mis", {31'b0, mis_b}, 32'h1);
        chk("t5_noalign_pc", pc_a, 32'h102);
        chk("t5_noalign_mis", {31'b0, mis_a}, 32'h0);
        step();
        chk("t5_mis_pulse", {31'b0, mis_b}, 32'h0);
        chk("t5_pc11", pc_b, 32'h11);
        branch_taken_i = 1'b1;
        branch_addr_i  = 32'h104;
        step();
        branch_taken_i = 1'b0;
        chk("t5_pc104", pc_b, 32'h104);
        chk("t5_mis_ok", {31'b0, mis_b}, 32'h0);

        // Test 6: wrap at all-ones, then async reset mid-stall with a redirect pending.
        branch_taken_i = 1'b1;
        branch_addr_i  = 32'hFFFF_FFFF;
        step();
        branch_taken_i = 1'b0;
        chk("t6_pcmax", pc_a, 32'hFFFF_FFFF);
        #1 chk("t6_pcnext_wrap", pc_next_a, 32'h0);
        step();
        chk("t6_wrap", pc_a, 32'h0);
        step();
        chk("t6_pc1", pc_a, 32'h1);
        stall_i = 1'b1;
        branch_taken_i = 1'b1;
        branch_addr_i  = 32'h200;
        step();
        branch_taken_i = 1'b0;
        chk("t6_pend", {31'b0, pend_a}, 32'h1);
        chk("t6_hold", pc_a, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_pc", pc_a, 32'h0);
        chk("t6_rst_pend", {31'b0, pend_a}, 32'h0);
        chk("t6_rst_pendb", {31'b0, pend_b}, 32'h0);
        chk("t6_rst_pcnext", pc_next_a, 32'h0);
        chk("t6_rst_fv", {31'b0, fv_a}, 32'h0);
        stall_i = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("t6_post_pc", pc_a, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
